decode_stage_pipe: RTL



---
 rtl/decode_pkg.sv | 40 ++++
 rtl/decode_regfile.sv | 44 ++++
 rtl/decode_stage_pipe.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : decode_pkg
//  Brief    : Shared field positions, ID/EX record type and sign-extension
//             helper for the WISC decode stage.
//  Revision : 1.0 - initial release
// ============================================================================
package decode_pkg;

   // Instruction field positions for the 16-bit WISC encoding
   localparam int INSTR_W    = 16;
   localparam int RS_HI      = 10;
   localparam int RS_LO      = 8;
   localparam int RT_HI      = 7;
   localparam int RT_LO      = 5;
   localparam int IMM5_W     = 5;
   localparam int IMM8_W     = 8;
   localparam int DISP11_W   = 11;

   // Widest datapath the extension helper supports
   localparam int SEXT_MAX_W = 64;

   // Width-independent portion of the ID/EX pipeline register
   typedef struct packed {
      logic               valid;
      logic [INSTR_W-1:0] instr;
   } id_ex_t;

   // Sign-extend the low 'width' bits of value to SEXT_MAX_W bits
   function automatic logic [SEXT_MAX_W-1:0] sext(input logic [SEXT_MAX_W-1:0] value,
                                                  input int unsigned            width);
      logic [SEXT_MAX_W-1:0] mask;
      logic                  sign;
      mask = {SEXT_MAX_W{1'b1}} << width;
      sign = |(value & ({{(SEXT_MAX_W-1){1'b0}}, 1'b1} << (width - 1)));
      return sign ? (value | mask) : (value & ~mask);
   endfunction

endpackage : decode_pkg
`default_nettype wire

// File: rtl/decode_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : decode_regfile
//  Brief    : NUM_REGS x DATA_W architectural register file with two
//             asynchronous read ports and one synchronous write port.
//  Revision : 1.0 - initial release
// ============================================================================
module decode_regfile
   import decode_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 8,
   parameter int REG_AW   = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [REG_AW-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [REG_AW-1:0] rd_addr_1,
   output logic [DATA_W-1:0] rd_data_1,
   input  logic [REG_AW-1:0] rd_addr_2,
   output logic [DATA_W-1:0] rd_data_2
);

   logic [DATA_W-1:0] r_regs [NUM_REGS];

   // Clear every register on reset, otherwise perform the single write
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (wr_en) begin
         r_regs[wr_addr] <= wr_data;
      end
   end

   // Reads see the current contents; the parent decides about bypassing
   assign rd_data_1 = r_regs[rd_addr_1];
   assign rd_data_2 = r_regs[rd_addr_2];

endmodule : decode_regfile
`default_nettype wire

// File: rtl/decode_stage_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : decode_stage_pipe
//  Brief    : Registered WISC decode stage: register file, operand read,
//             immediate extension and ID/EX pipeline register with
//             valid/stall/flush control.
//  Config   : define REGFILE_BYPASS_EN for write-before-read operand capture
//             and refresh of held operands while stalled.
//  Revision : 1.0 - initial release
// ============================================================================
module decode_stage_pipe
   import decode_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 8,
   parameter int REG_AW   = $clog2(NUM_REGS)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               if_valid,
   input  logic [15:0]        if_instr,
   input  logic [DATA_W-1:0]  if_pc,
   input  logic               imm_zext,
   input  logic               stall,
   input  logic               flush,
   input  logic               wb_en,
   input  logic [REG_AW-1:0]  wb_addr,
   input  logic [DATA_W-1:0]  wb_data,
   output logic               id_valid,
   output logic [15:0]        id_instr,
   output logic [DATA_W-1:0]  id_pc,
   output logic [DATA_W-1:0]  read_data_1,
   output logic [DATA_W-1:0]  read_data_2,
   output logic [DATA_W-1:0]  i_1,
   output logic [DATA_W-1:0]  i_2,
   output logic [DATA_W-1:0]  word_align_jump
);

   // Source register fields, truncated to the register address width
   logic [REG_AW-1:0] w_rs;
   logic [REG_AW-1:0] w_rt;
   assign w_rs = if_instr[RS_LO +: REG_AW];
   assign w_rt = if_instr[RT_LO +: REG_AW];

   logic [DATA_W-1:0] w_rf_rd1;
   logic [DATA_W-1:0] w_rf_rd2;

   decode_regfile #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .REG_AW   (REG_AW)
   ) u_regfile (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wb_en),
      .wr_addr   (wb_addr),
      .wr_data   (wb_data),
      .rd_addr_1 (w_rs),
      .rd_data_1 (w_rf_rd1),
      .rd_addr_2 (w_rt),
      .rd_data_2 (w_rf_rd2)
   );

   // Operand values presented to the capture path
   logic [DATA_W-1:0] w_op1;
   logic [DATA_W-1:0] w_op2;

`ifdef REGFILE_BYPASS_EN
   // Held instruction's source fields, used to refresh operands while stalled
   logic [REG_AW-1:0] w_held_rs;
   logic [REG_AW-1:0] w_held_rt;

   assign w_op1 = (wb_en && (wb_addr == w_rs)) ? wb_data : w_rf_rd1;
   assign w_op2 = (wb_en && (wb_addr == w_rt)) ? wb_data : w_rf_rd2;
`else
   assign w_op1 = w_rf_rd1;
   assign w_op2 = w_rf_rd2;
`endif

   // Immediate operands extended to the datapath width
   logic [DATA_W-1:0] w_imm5;
   logic [DATA_W-1:0] w_imm8;
   logic [DATA_W-1:0] w_disp11;

   assign w_imm5   = imm_zext ? DATA_W'(if_instr[IMM5_W-1:0])
                              : DATA_W'(sext(SEXT_MAX_W'(if_instr[IMM5_W-1:0]), IMM5_W));
   assign w_imm8   = DATA_W'(sext(SEXT_MAX_W'(if_instr[IMM8_W-1:0]), IMM8_W));
   assign w_disp11 = DATA_W'(sext(SEXT_MAX_W'(if_instr[DISP11_W-1:0]), DISP11_W));

   // ID/EX pipeline register state
   id_ex_t            r_id;
   logic [DATA_W-1:0] r_pc;
   logic [DATA_W-1:0] r_rd1;
   logic [DATA_W-1:0] r_rd2;
   logic [DATA_W-1:0] r_i1;
   logic [DATA_W-1:0] r_i2;
   logic [DATA_W-1:0] r_disp;

`ifdef REGFILE_BYPASS_EN
   assign w_held_rs = r_id.instr[RS_LO +: REG_AW];
   assign w_held_rt = r_id.instr[RT_LO +: REG_AW];
`endif

   // ID/EX update with priority reset > flush > stall > capture
   always_ff @(posedge clk) begin
      if (rst) begin
         r_id   <= '0;
         r_pc   <= '0;
         r_rd1  <= '0;
         r_rd2  <= '0;
         r_i1   <= '0;
         r_i2   <= '0;
         r_disp <= '0;
      end else if (flush) begin
         // Fields are don't-care once the slot is invalid, so they simply hold
         r_id.valid <= 1'b0;
      end else if (stall) begin
`ifdef REGFILE_BYPASS_EN
         // Keep held operands coherent with writebacks landing during the stall
         if (wb_en && (wb_addr == w_held_rs)) begin
            r_rd1 <= wb_data;
         end
         if (wb_en && (wb_addr == w_held_rt)) begin
            r_rd2 <= wb_data;
         end
`endif
      end else begin
         // Bubbles still load the fields; only valid distinguishes them
         r_id.valid <= if_valid;
         r_id.instr <= if_instr;
         r_pc       <= if_pc;
         r_rd1      <= w_op1;
         r_rd2      <= w_op2;
         r_i1       <= w_imm5;
         r_i2       <= w_imm8;
         r_disp     <= w_disp11;
      end
   end

   assign id_valid        = r_id.valid;
   assign id_instr        = r_id.instr;
   assign id_pc           = r_pc;
   assign read_data_1     = r_rd1;
   assign read_data_2     = r_rd2;
   assign i_1             = r_i1;
   assign i_2             = r_i2;
   assign word_align_jump = r_disp;

endmodule : decode_stage_pipe
`default_nettype wire
